// File: rtl/mp64_nic_rxq_pkg.sv
// mp64_nic_rxq_pkg
// Shared types and defaults for the receive-side frame queue.
//   MP64_NIC_MAX_FRAME : default largest accepted frame, in bytes
//   MP64_NIC_IFG       : default minimum idle cycles between replayed frames
//   frame_len_t        : 12-bit frame length (1..4095 representable)
//   rd_state_e         : replay FSM state encoding
package mp64_nic_rxq_pkg;

    localparam int MP64_NIC_MAX_FRAME = 1536;
    localparam int MP64_NIC_IFG       = 2;
    localparam int LEN_W              = 12;

    typedef logic [LEN_W-1:0] frame_len_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_LOAD   = 2'd1,
        RD_STREAM = 2'd2,
        RD_GAP    = 2'd3
    } rd_state_e;

endpackage

// File: rtl/mp64_nic_rxq_lenfifo.sv
// mp64_nic_rxq_lenfifo
// Synchronous show-ahead FIFO holding the lengths of committed frames.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full)
//   push_data  : frame length to store
//   pop        : drop the head entry (ignored when empty)
//   pop_data   : current head entry, valid whenever empty is low
//   full/empty : occupancy flags
//   count      : number of stored entries
module mp64_nic_rxq_lenfifo
    import mp64_nic_rxq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  frame_len_t       push_data,
    input  logic             pop,
    output frame_len_t       pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] IDX_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0] IDX_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    frame_len_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] rd_idx;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= '0;
            rd_idx <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_idx] <= push_data;
                wr_idx      <= (wr_idx == IDX_LAST) ? '0 : wr_idx + IDX_ONE;
            end
            if (pop_ok) begin
                rd_idx <= (rd_idx == IDX_LAST) ? '0 : rd_idx + IDX_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mp64_nic_rxq.sv
// mp64_nic_rxq
// Receive frame queue between the external link PHY and the NIC PHY RX port.
// Bytes arrive unstallable with arbitrary gaps; complete good frames are
// committed and replayed to the NIC as one contiguous burst. Errored,
// oversized or non-fitting frames are rewound and counted.
//   clk, rst_n      : clock, asynchronous active-low reset
//   ext_rx_*        : byte strobe/data/last/err from the external PHY
//   phy_rx_valid    : byte valid, held high for the whole replayed frame
//   phy_rx_data     : replayed byte
//   phy_rx_ready    : NIC accepts the current byte
//   frames_pending  : committed frames waiting for replay
//   drop_count      : saturating count of discarded frames
//   overflow        : one-cycle pulse per discarded frame
//
// Replay FSM
//   state     | meaning
//   ----------+----------------------------------------------------------
//   RD_IDLE   | nothing to replay; pops a length as soon as one is queued
//   RD_LOAD   | first byte read in flight; valid rises on exit
//   RD_STREAM | valid high, advancing one byte per accepted handshake
//   RD_GAP    | valid low; the final GAP cycle may pop the next length so
//             | that LOAD itself is the last idle cycle before the next frame
module mp64_nic_rxq
    import mp64_nic_rxq_pkg::*;
#(
    parameter int ADDR_W    = 11,
    parameter int MAX_FRAME = MP64_NIC_MAX_FRAME,
    parameter int LEN_DEPTH = 4,
    parameter int IFG       = MP64_NIC_IFG
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_rx_valid,
    input  logic [7:0]  ext_rx_data,
    input  logic        ext_rx_last,
    input  logic        ext_rx_err,
    output logic        phy_rx_valid,
    output logic [7:0]  phy_rx_data,
    input  logic        phy_rx_ready,
    output logic [2:0]  frames_pending,
    output logic [15:0] drop_count,
    output logic        overflow
);

    localparam int DEPTH_B = 2 ** ADDR_W;
    localparam int CNT_W   = $clog2(LEN_DEPTH + 1);
    localparam int GAP_W   = (IFG > 1) ? $clog2(IFG + 1) : 1;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_TWO  = ADDR_W'(2);
    localparam frame_len_t        LEN_ONE  = frame_len_t'(1);
    localparam frame_len_t        LEN_MAX  = frame_len_t'(MAX_FRAME);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(IFG - 1);

    logic [7:0]        byte_mem [DEPTH_B];
    logic [7:0]        ram_q;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_raddr;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] commit_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_base;
    frame_len_t        cur_len;
    logic              frame_bad;

    logic              buf_full;
    logic              len_ok;
    logic              wr_en;
    logic              frame_end;
    logic              frame_good;
    logic              frame_drop;

    logic              len_pop;
    frame_len_t        len_head;
    logic              len_full;
    logic              len_empty;
    logic [CNT_W-1:0]  len_count;

    rd_state_e         state;
    rd_state_e         state_nxt;
    frame_len_t        rem_len;
    logic [GAP_W-1:0]  gap_cnt;
    logic              gap_done;
    logic              xfer;
    logic              last_byte;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    // One slot is always left free so that a write can never land on the
    // byte the replay side still owns (rd_base marks the oldest such byte).
    assign buf_full   = ((wr_ptr + PTR_ONE) == rd_base);
    assign len_ok     = (cur_len < LEN_MAX);
    assign wr_en      = ext_rx_valid && !frame_bad && !buf_full && len_ok;
    assign frame_end  = ext_rx_valid && ext_rx_last;
    assign frame_good = frame_end && wr_en && !ext_rx_err && !len_full;
    assign frame_drop = frame_end && !frame_good;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            cur_len    <= '0;
            frame_bad  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            overflow <= frame_drop;
            if (frame_end) begin
                if (frame_good) begin
                    wr_ptr     <= wr_ptr + PTR_ONE;
                    commit_ptr <= wr_ptr + PTR_ONE;
                end else begin
                    wr_ptr <= commit_ptr;
                end
                cur_len   <= '0;
                frame_bad <= 1'b0;
            end else if (ext_rx_valid) begin
                if (wr_en) begin
                    wr_ptr  <= wr_ptr + PTR_ONE;
                    cur_len <= cur_len + LEN_ONE;
                end else begin
                    // sticky until last: the rest of the frame is ignored
                    frame_bad <= 1'b1;
                end
            end
            if (frame_drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Byte RAM: registered read port, write port driven by the PHY side.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            byte_mem[wr_ptr] <= ext_rx_data;
        end
        if (ram_rd_en) begin
            ram_q <= byte_mem[ram_raddr];
        end
    end

    mp64_nic_rxq_lenfifo #(
        .DEPTH (LEN_DEPTH),
        .CNT_W (CNT_W)
    ) u_lenfifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (frame_good),
        .push_data (cur_len + LEN_ONE),
        .pop       (len_pop),
        .pop_data  (len_head),
        .full      (len_full),
        .empty     (len_empty),
        .count     (len_count)
    );

    assign frames_pending = 3'(len_count);

    // ------------------------------------------------------------------
    // Replay side
    // ------------------------------------------------------------------
    assign xfer      = (state == RD_STREAM) && phy_rx_valid && phy_rx_ready;
    assign last_byte = (rem_len == LEN_ONE);
    assign gap_done  = (gap_cnt <= GAP_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE:   if (!len_empty) state_nxt = RD_LOAD;
            RD_LOAD:   state_nxt = RD_STREAM;
            RD_STREAM: if (xfer && last_byte) state_nxt = RD_GAP;
            RD_GAP: begin
                if (gap_done) begin
                    state_nxt = len_empty ? RD_IDLE : RD_LOAD;
                end
            end
            default:   state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        len_pop   = 1'b0;
        ram_rd_en = 1'b0;
        ram_raddr = rd_ptr;
        case (state)
            RD_IDLE: begin
                if (!len_empty) begin
                    len_pop   = 1'b1;
                    ram_rd_en = 1'b1;
                end
            end
            RD_GAP: begin
                if (gap_done && !len_empty) begin
                    len_pop   = 1'b1;
                    ram_rd_en = 1'b1;
                end
            end
            RD_LOAD: begin
                ram_rd_en = 1'b1;
                ram_raddr = rd_ptr + PTR_ONE;
            end
            RD_STREAM: begin
                // prefetch the byte after the one about to become current
                if (xfer && !last_byte) begin
                    ram_rd_en = 1'b1;
                    ram_raddr = rd_ptr + PTR_TWO;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            rd_base      <= '0;
            rem_len      <= '0;
            gap_cnt      <= '0;
            phy_rx_valid <= 1'b0;
            phy_rx_data  <= '0;
        end else begin
            if (len_pop) begin
                rem_len <= len_head;
            end
            case (state)
                RD_LOAD: begin
                    phy_rx_data  <= ram_q;
                    phy_rx_valid <= 1'b1;
                end
                RD_STREAM: begin
                    if (xfer) begin
                        rd_ptr  <= rd_ptr + PTR_ONE;
                        rem_len <= rem_len - LEN_ONE;
                        if (last_byte) begin
                            phy_rx_valid <= 1'b0;
                            rd_base      <= rd_ptr + PTR_ONE;
                            gap_cnt      <= GAP_LOAD;
                        end else begin
                            phy_rx_data <= ram_q;
                        end
                    end
                end
                RD_GAP: begin
                    if (!gap_done) begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mp64_nic_rxq.sv
module tb_mp64_nic_rxq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_rx_valid;
    logic [7:0]  ext_rx_data;
    logic        ext_rx_last;
    logic        ext_rx_err;
    logic        phy_rx_valid;
    logic [7:0]  phy_rx_data;
    logic        phy_rx_ready;
    logic [2:0]  frames_pending;
    logic [15:0] drop_count;
    logic        overflow;

    always #5 clk = ~clk;

    // Small buffer and MAX_FRAME so buffer-full and oversize cases are cheap.
    mp64_nic_rxq #(
        .ADDR_W    (4),
        .MAX_FRAME (12),
        .LEN_DEPTH (4),
        .IFG       (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ext_rx_valid   (ext_rx_valid),
        .ext_rx_data    (ext_rx_data),
        .ext_rx_last    (ext_rx_last),
        .ext_rx_err     (ext_rx_err),
        .phy_rx_valid   (phy_rx_valid),
        .phy_rx_data    (phy_rx_data),
        .phy_rx_ready   (phy_rx_ready),
        .frames_pending (frames_pending),
        .drop_count     (drop_count),
        .overflow       (overflow)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    typedef struct {
        int         len;
        logic [7:0] first;
        logic [7:0] step;
        logic       err;
        int         gap;
        logic       good;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   exp_drops = 0;
    int   ovf_seen  = 0;
    int   low_run   = 0;
    int   rises     = 0;
    int   last_gap  = 0;
    int   pend_chk  = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor / scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_chk   = 0;
            prev_valid = 1'b0;
            low_run    = 0;
        end else begin
            if (pend_chk != 0) begin
                chk("valid_after_byte", {31'd0, phy_rx_valid}, (pend_chk == 2) ? 32'd1 : 32'd0);
                pend_chk = 0;
            end
            if (overflow) ovf_seen++;
            if (phy_rx_valid) begin
                if (!prev_valid) begin
                    last_gap = low_run;
                    rises++;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_valid = phy_rx_valid;
            if (phy_rx_valid && phy_rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got byte 0x%0h, expected no byte", phy_rx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rx_byte", {24'd0, phy_rx_data}, {24'd0, mon_e.d});
                    pend_chk = mon_e.last ? 1 : 2;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic last, input logic err);
        ext_rx_valid = 1'b1;
        ext_rx_data  = d;
        ext_rx_last  = last;
        ext_rx_err   = err;
        @(posedge clk);
        #1;
        ext_rx_valid = 1'b0;
        ext_rx_last  = 1'b0;
        ext_rx_err   = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] first, input logic [7:0] step,
                              input logic err, input int gap, input logic good);
        logic [7:0] b;
        logic       lst;
        exp_t       e;
        b = first;
        for (int i = 0; i < len; i++) begin
            lst = (i == len - 1);
            if (good) begin
                e.d    = b;
                e.last = lst;
                exp_q.push_back(e);
            end
            push_byte(b, lst, err && lst);
            if (!lst) idle(gap);
            b = b + step;
        end
        if (!good) exp_drops++;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || phy_rx_valid || frames_pending != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", (n >= budget) ? 32'd1 : 32'd0, 32'd0);
        idle(4);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!phy_rx_valid && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("valid_rise", {31'd0, phy_rx_valid}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[7];

    initial begin
        logic [7:0] b;

        vecs[0] = '{len: 4,  first: 8'hAA, step: 8'h11, err: 1'b0, gap: 2, good: 1'b1};
        vecs[1] = '{len: 1,  first: 8'h5A, step: 8'h01, err: 1'b0, gap: 0, good: 1'b1};
        vecs[2] = '{len: 5,  first: 8'h60, step: 8'h01, err: 1'b1, gap: 1, good: 1'b0};
        vecs[3] = '{len: 1,  first: 8'hEE, step: 8'h01, err: 1'b0, gap: 0, good: 1'b1};
        vecs[4] = '{len: 12, first: 8'h80, step: 8'h01, err: 1'b0, gap: 0, good: 1'b1};
        vecs[5] = '{len: 13, first: 8'hC0, step: 8'h01, err: 1'b0, gap: 0, good: 1'b0};
        vecs[6] = '{len: 3,  first: 8'h11, step: 8'h11, err: 1'b0, gap: 1, good: 1'b1};

        rst_n        = 1'b0;
        ext_rx_valid = 1'b0;
        ext_rx_data  = 8'h00;
        ext_rx_last  = 1'b0;
        ext_rx_err   = 1'b0;
        phy_rx_ready = 1'b1;
        idle(3);
        chk("rst_valid",   {31'd0, phy_rx_valid},   32'd0);
        chk("rst_data",    {24'd0, phy_rx_data},    32'd0);
        chk("rst_pending", {29'd0, frames_pending}, 32'd0);
        chk("rst_drops",   {16'd0, drop_count},     32'd0);
        chk("rst_ovf",     {31'd0, overflow},       32'd0);
        rst_n = 1'b1;
        idle(2);

        // Single-frame vectors: gappy input, length 1, error, max, oversize.
        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].len, vecs[i].first, vecs[i].step, vecs[i].err,
                       vecs[i].gap, vecs[i].good);
            wait_drain(200);
            chk("vec_drops",   {16'd0, drop_count},     exp_drops);
            chk("vec_ovf",     ovf_seen,                exp_drops);
            chk("vec_pending", {29'd0, frames_pending}, 32'd0);
        end

        // Back-to-back frames: exactly IFG idle cycles between bursts.
        phy_rx_ready = 1'b0;
        send_frame(3, 8'h11, 8'h11, 1'b0, 0, 1'b1);
        send_frame(2, 8'h44, 8'h11, 1'b0, 0, 1'b1);
        idle(3);
        chk("b2b_pending", {29'd0, frames_pending}, 32'd1);
        rises        = 0;
        phy_rx_ready = 1'b1;
        wait_drain(200);
        chk("b2b_rises", rises,    32'd1);
        chk("b2b_gap",   last_gap, 32'd2);

        // Backpressure: stall three cycles with byte 04 presented.
        phy_rx_ready = 1'b0;
        send_frame(8, 8'h01, 8'h01, 1'b0, 0, 1'b1);
        wait_valid(50);
        phy_rx_ready = 1'b1;
        idle(3);
        phy_rx_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, phy_rx_valid}, 32'd1);
            chk("stall_data",  {24'd0, phy_rx_data},  32'h04);
        end
        @(posedge clk);
        #1;
        phy_rx_ready = 1'b1;
        wait_drain(200);

        // Buffer full: a held 10-byte frame leaves no room for another 10.
        phy_rx_ready = 1'b0;
        send_frame(10, 8'h30, 8'h01, 1'b0, 0, 1'b1);
        send_frame(10, 8'h50, 8'h01, 1'b0, 0, 1'b0);
        idle(2);
        chk("full_drops",   {16'd0, drop_count},     exp_drops);
        chk("full_pending", {29'd0, frames_pending}, 32'd0);
        phy_rx_ready = 1'b1;
        wait_drain(200);
        chk("full_ovf", ovf_seen, exp_drops);

        // Length FIFO full: one frame in replay plus four queued, sixth dropped.
        phy_rx_ready = 1'b0;
        b = 8'h90;
        for (int k = 0; k < 5; k++) begin
            send_frame(2, b, 8'h01, 1'b0, 0, 1'b1);
            b = b + 8'h10;
        end
        idle(2);
        chk("lfull_pending4", {29'd0, frames_pending}, 32'd4);
        send_frame(2, 8'hF0, 8'h01, 1'b0, 0, 1'b0);
        idle(2);
        chk("lfull_pending_after", {29'd0, frames_pending}, 32'd4);
        chk("lfull_drops",         {16'd0, drop_count},     exp_drops);
        phy_rx_ready = 1'b1;
        wait_drain(300);
        chk("lfull_ovf", ovf_seen, exp_drops);

        // Reset in the middle of a stalled replay with another frame queued.
        phy_rx_ready = 1'b0;
        send_frame(4, 8'h21, 8'h01, 1'b0, 0, 1'b1);
        send_frame(2, 8'h41, 8'h01, 1'b0, 0, 1'b1);
        wait_valid(50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, phy_rx_valid}, 32'd0);
        exp_q.delete();
        exp_drops = 0;
        ovf_seen  = 0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("rst_mid_pending", {29'd0, frames_pending}, 32'd0);
        chk("rst_mid_drops",   {16'd0, drop_count},     32'd0);
        chk("rst_mid_valid2",  {31'd0, phy_rx_valid},   32'd0);
        phy_rx_ready = 1'b1;
        send_frame(3, 8'h77, 8'h01, 1'b0, 0, 1'b1);
        wait_drain(200);
        chk("post_rst_drops", {16'd0, drop_count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
